// File: rtl/mis_stim_sequencer.sv
// MIS test-structure sequencer: drives two NOR-chain inputs with programmable skew
// and timestamps the synchronized output transition for each rise/fall phase.
module mis_stim_sequencer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned REP_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] skew,
  input  logic             b_first,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic [REP_W-1:0] num_reps,
  input  logic             dut_out,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic             meas_phase,
  output logic [REP_W-1:0] rep_idx,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, RISE1, SKEW, WAIT_R, HOLD, FALL, WAIT_F, DONE
  } state_t;

  state_t state, state_n;

  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             captured, cap_n;
  logic [CNT_W-1:0] skew_q, skew_n, hold_q, hold_n;
  logic [REP_W-1:0] reps_q, reps_n, rep_n;
  logic             bf_q, bf_n;
  logic             a_n, b_n, busy_n, done_n, mv_n, mp_n, to_n;
  logic [CNT_W-1:0] md_n;

  logic edge_det, armed, capture, timed_out;

  assign edge_det  = s2 ^ s3;
  assign armed     = (state == SKEW) || (state == WAIT_R) || (state == WAIT_F);
  assign capture   = armed && edge_det && !captured;
  assign timed_out = cnt >= TO_VAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      captured    <= 1'b0;
      skew_q      <= '0;
      hold_q      <= '0;
      reps_q      <= '0;
      bf_q        <= 1'b0;
      dut_a       <= 1'b0;
      dut_b       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      meas_valid  <= 1'b0;
      meas_delay  <= '0;
      meas_phase  <= 1'b0;
      rep_idx     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      s1          <= dut_out;
      s2          <= s1;
      s3          <= s2;
      cnt         <= cnt_n;
      captured    <= cap_n;
      skew_q      <= skew_n;
      hold_q      <= hold_n;
      reps_q      <= reps_n;
      bf_q        <= bf_n;
      dut_a       <= a_n;
      dut_b       <= b_n;
      busy        <= busy_n;
      done        <= done_n;
      meas_valid  <= mv_n;
      meas_delay  <= md_n;
      meas_phase  <= mp_n;
      rep_idx     <= rep_n;
      timeout_err <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    cap_n   = captured;
    skew_n  = skew_q;
    hold_n  = hold_q;
    reps_n  = reps_q;
    bf_n    = bf_q;
    a_n     = dut_a;
    b_n     = dut_b;
    busy_n  = busy;
    done_n  = 1'b0;
    mv_n    = 1'b0;
    md_n    = meas_delay;
    mp_n    = meas_phase;
    rep_n   = rep_idx;
    to_n    = timeout_err;

    // First detected output edge of the phase wins; later edges are ignored.
    if (capture) begin
      mv_n  = 1'b1;
      md_n  = cnt;
      mp_n  = (state == WAIT_F);
      cap_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (num_reps == '0) begin
            done_n = 1'b1;
          end else begin
            skew_n  = skew;
            hold_n  = hold_cycles;
            reps_n  = num_reps;
            bf_n    = b_first;
            busy_n  = 1'b1;
            to_n    = 1'b0;
            rep_n   = '0;
            state_n = RISE1;
          end
        end
      end
      RISE1: begin
        cnt_n = '0;
        cap_n = 1'b0;
        if (skew_q == '0) begin
          a_n     = 1'b1;
          b_n     = 1'b1;
          state_n = WAIT_R;
        end else begin
          if (bf_q) b_n = 1'b1;
          else      a_n = 1'b1;
          state_n = SKEW;
        end
      end
      SKEW: begin
        if (cnt == skew_q - CNT_W'(1)) begin
          a_n     = 1'b1;
          b_n     = 1'b1;
          state_n = WAIT_R;
        end
      end
      WAIT_R: begin
        // A capture in this cycle takes precedence; exit on the following cycle.
        if (captured || (!capture && timed_out)) begin
          if (!captured) to_n = 1'b1;
          cnt_n   = '0;
          state_n = (hold_q == '0) ? FALL : HOLD;
        end
      end
      HOLD: begin
        if (cnt == hold_q - CNT_W'(1)) state_n = FALL;
      end
      FALL: begin
        a_n     = 1'b0;
        b_n     = 1'b0;
        cnt_n   = '0;
        cap_n   = 1'b0;
        state_n = WAIT_F;
      end
      WAIT_F: begin
        if (captured || (!capture && timed_out)) begin
          if (!captured) to_n = 1'b1;
          if (rep_idx == reps_q - REP_W'(1)) begin
            state_n = DONE;
          end else begin
            rep_n   = rep_idx + REP_W'(1);
            state_n = RISE1;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mis_stim_sequencer.sv
// Directed bench for mis_stim_sequencer using NOR2, delayed-NOR and stuck-low chain models.
module tb_mis_stim_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] skew;
  logic             b_first;
  logic [CNT_W-1:0] hold_cycles;
  logic [REP_W-1:0] num_reps;
  logic             dut_out;
  logic             dut_a, dut_b, busy, done, meas_valid, meas_phase, timeout_err;
  logic [CNT_W-1:0] meas_delay;
  logic [REP_W-1:0] rep_idx;

  int ncmp = 0;
  int nfail = 0;

  // Chain model: 0 = zero-delay NOR2, 1 = NOR2 delayed 10 cycles, 2 = stuck low.
  int         mode = 0;
  logic [9:0] dly = '1;
  always @(posedge clk) dly <= {dly[8:0], ~(dut_a | dut_b)};
  assign dut_out = (mode == 0) ? ~(dut_a | dut_b) : (mode == 1) ? dly[9] : 1'b0;

  always #5 clk = ~clk;

  mis_stim_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .TIMEOUT_CYC(200)) u_dut (
    .clk(clk), .rst(rst), .start(start), .skew(skew), .b_first(b_first),
    .hold_cycles(hold_cycles), .num_reps(num_reps), .dut_out(dut_out),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
    .meas_valid(meas_valid), .meas_delay(meas_delay), .meas_phase(meas_phase),
    .rep_idx(rep_idx), .timeout_err(timeout_err)
  );

  int         nmeas;
  logic [7:0] mdel [16];
  logic       mph  [16];
  logic [7:0] mrep [16];
  int         a_rise, b_rise, a_high, b_high, busy_cnt, done_cyc;
  logic       busy_drop, to_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start and record activity, sampled on negedges, until done or the limit.
  task automatic run(input logic [7:0] sk, input logic bf, input logic [7:0] hd,
                     input logic [7:0] nr, input int limit);
    logic pa, pb;
    nmeas = 0; a_rise = -1; b_rise = -1; a_high = 0; b_high = 0;
    busy_cnt = 0; done_cyc = 0; busy_drop = 1'b0; to_first = 1'b0;
    pa = dut_a; pb = dut_b;
    @(negedge clk);
    skew = sk; b_first = bf; hold_cycles = hd; num_reps = nr; start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) to_first = timeout_err;
      if (meas_valid) begin
        if (nmeas < 16) begin
          mdel[nmeas] = meas_delay;
          mph[nmeas]  = meas_phase;
          mrep[nmeas] = rep_idx;
        end
        nmeas++;
      end
      if (dut_a && !pa && a_rise < 0) a_rise = c;
      if (dut_b && !pb && b_rise < 0) b_rise = c;
      if (dut_a) a_high++;
      if (dut_b) b_high++;
      if (busy) busy_cnt++;
      if (!busy && !done) busy_drop = 1'b1;
      pa = dut_a; pb = dut_b;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("run_reached_done", 32'(done_cyc > 0), 32'd1);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; skew = '0; b_first = 1'b0; hold_cycles = '0; num_reps = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", 32'({dut_a, dut_b, busy, done, meas_valid, meas_phase, timeout_err}), 32'd0);
    check("reset_delay", 32'(meas_delay), 32'd0);
    check("reset_rep_idx", 32'(rep_idx), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Zero-delay NOR, skew 0, one rep, hold 3.
    run(8'd0, 1'b0, 8'd3, 8'd1, 100);
    check("t1_done_cyc", 32'(done_cyc), 32'd15);
    check("t1_nmeas", 32'(nmeas), 32'd2);
    check("t1_delay_rise", 32'(mdel[0]), 32'd2);
    check("t1_phase_rise", 32'(mph[0]), 32'd0);
    check("t1_delay_fall", 32'(mdel[1]), 32'd2);
    check("t1_phase_fall", 32'(mph[1]), 32'd1);
    check("t1_a_rise", 32'(a_rise), 32'd2);
    check("t1_b_rise", 32'(b_rise), 32'd2);
    check("t1_a_high", 32'(a_high), 32'd8);
    check("t1_busy_drop", 32'(busy_drop), 32'd0);
    check("t1_busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(negedge clk);

    // Skew 5, A first, three reps.
    run(8'd5, 1'b0, 8'd2, 8'd3, 300);
    check("t2_nmeas", 32'(nmeas), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_delay_%0d", i), 32'(mdel[i]), 32'd2);
      check($sformatf("t2_phase_%0d", i), 32'(mph[i]), 32'(i % 2));
      check($sformatf("t2_rep_%0d", i), 32'(mrep[i]), 32'(i / 2));
    end
    check("t2_a_rise", 32'(a_rise), 32'd2);
    check("t2_b_rise", 32'(b_rise), 32'd7);
    check("t2_busy_drop", 32'(busy_drop), 32'd0);
    repeat (4) @(negedge clk);

    // Skew 3, B first.
    run(8'd3, 1'b1, 8'd0, 8'd1, 100);
    check("t2b_nmeas", 32'(nmeas), 32'd2);
    check("t2b_b_rise", 32'(b_rise), 32'd2);
    check("t2b_a_rise", 32'(a_rise), 32'd5);
    check("t2b_delay", 32'(mdel[0]), 32'd2);
    repeat (4) @(negedge clk);

    // Output delayed by 10 cycles.
    mode = 1;
    repeat (12) @(negedge clk);
    run(8'd0, 1'b0, 8'd2, 8'd2, 200);
    check("t3_nmeas", 32'(nmeas), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_delay_%0d", i), 32'(mdel[i]), 32'd12);
    mode = 0;
    repeat (12) @(negedge clk);

    // Output stuck low: both phases time out.
    mode = 2;
    repeat (6) @(negedge clk);
    run(8'd0, 1'b0, 8'd0, 8'd1, 1000);
    check("t4_nmeas", 32'(nmeas), 32'd0);
    check("t4_a_high", 32'(a_high), 32'd202);
    check("t4_done_cyc", 32'(done_cyc), 32'd406);
    mode = 0;
    repeat (6) @(negedge clk);
    check("t4_timeout_sticky", 32'(timeout_err), 32'd1);
    run(8'd0, 1'b0, 8'd0, 8'd1, 100);
    check("t4_timeout_cleared_at_start", 32'(to_first), 32'd0);
    check("t4_timeout_after_good_run", 32'(timeout_err), 32'd0);
    check("t4_good_nmeas", 32'(nmeas), 32'd2);
    repeat (4) @(negedge clk);

    // Zero repetitions.
    run(8'd4, 1'b0, 8'd1, 8'd0, 5);
    check("t5_done_cyc", 32'(done_cyc), 32'd1);
    check("t5_busy_cnt", 32'(busy_cnt), 32'd0);
    check("t5_a_high", 32'(a_high), 32'd0);
    check("t5_b_high", 32'(b_high), 32'd0);
    @(negedge clk);
    check("t5_done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during SKEW; start while busy is ignored.
    skew = 8'd20; b_first = 1'b0; hold_cycles = 8'd1; num_reps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_in_skew", 32'({busy, dut_a, dut_b}), 32'b110);
    num_reps = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_start_ignored", 32'({busy, done}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_flags", 32'({dut_a, dut_b, busy, done, meas_valid, timeout_err}), 32'd0);
    check("t6_reset_rep_delay", 32'({rep_idx, meas_delay}), 32'd0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("t6_no_done_after_abort", 32'(dcount), 32'd0);
    run(8'd0, 1'b0, 8'd3, 8'd1, 100);
    check("t6_rerun_done_cyc", 32'(done_cyc), 32'd15);
    check("t6_rerun_nmeas", 32'(nmeas), 32'd2);
    check("t6_rerun_delay", 32'(mdel[0]), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
